// File: rtl/sar_adc_control.sv
// Successive-approximation ADC sequencer: binary-searches the comparator against the R2R DAC
// and owns the DAC code while a conversion runs; shows the last result when idle.
module sar_adc_control #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             cont,
  input  logic             comp,
  output logic [WIDTH-1:0] dac_out,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {IDLE, TRIAL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [1:0]       sync_q;
  logic             comp_s;

  assign comp_s = sync_q[1];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      sync_q   <= '0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      sync_q   <= {sync_q[0], comp};
    end
  end

  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = TRIAL;
          trial_d = MSB_CODE;
          idx_d   = IDX_MSB;
          cnt_d   = '0;
        end
      end
      TRIAL: begin
        if (cnt_q == CNT_LAST) begin
          // Evaluation edge: settle the current bit and arm the next one together.
          trial_d[idx_q] = comp_s;
          cnt_d          = '0;
          if (idx_q != '0) begin
            trial_d[idx_q - 1'b1] = 1'b1;
            idx_d                 = idx_q - 1'b1;
          end else begin
            result_d = trial_d;
            done_d   = 1'b1;
            if (cont) begin
              trial_d = MSB_CODE;
              idx_d   = IDX_MSB;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == TRIAL);
  assign dac_out = busy ? trial_q : result_q;
  assign result  = result_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sar_adc_control.sv
// Directed/randomized bench for sar_adc_control: an ideal comparator driven by a target code,
// checked against a plain binary-search reference for trial codes, result and timing.
module tb_sar_adc_control;

  logic       clk = 1'b0;
  logic       n_rst, start, cont, start3, cont3;
  logic       comp = 1'b0, comp3 = 1'b0;
  logic [7:0] dac_out, result, dac_out3, result3;
  logic       busy, done, busy3, done3;
  logic [7:0] vin = 8'h00, vin3 = 8'h00;
  int         tests = 0, fails = 0;

  always #5 clk = ~clk;

  sar_adc_control #(.WIDTH(8), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .cont(cont), .comp(comp),
    .dac_out(dac_out), .result(result), .busy(busy), .done(done)
  );

  sar_adc_control #(.WIDTH(8), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .n_rst(n_rst), .start(start3), .cont(cont3), .comp(comp3),
    .dac_out(dac_out3), .result(result3), .busy(busy3), .done(done3)
  );

  // Comparator: random garbage early in each cycle, the true answer from mid-cycle on
  always begin
    @(posedge clk);
    #1;
    comp  = 1'($urandom_range(0, 1));
    comp3 = 1'($urandom_range(0, 1));
    @(negedge clk);
    comp  = (vin >= dac_out);
    comp3 = (vin3 >= dac_out3);
  end

  // Reference: code presented at binary-search step `step` while searching for v
  function automatic logic [7:0] trial_code(input logic [7:0] v, input int step);
    logic [7:0] code;
    logic [7:0] bitv;
    code = 8'h00;
    for (int j = 0; j < step; j++) begin
      bitv = 8'h80 >> j;
      if (v >= (code | bitv)) code = code | bitv;
    end
    return code | (8'h80 >> step);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic conv(input logic [7:0] v, input bit do_start, input bit cont_exp,
                      input logic [7:0] next_v, input int pa, input int pb, input int drop_at);
    int c0;
    vin = v;
    if (do_start) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      c0 = 0;
    end else begin
      @(posedge clk);
      c0 = 1;
    end
    for (int c = c0; c < 32; c++) begin
      @(negedge clk);
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      chk("dac_seq", dac_out, trial_code(v, c / 4));
      start = (c == pa || c == pb);
      if (c == drop_at) cont = 1'b0;
      if (c == 30) vin = next_v;
      @(posedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    chk("done", done, 1);
    chk("result", result, v);
    chk("busy_end", busy, cont_exp);
    chk("dac_end", dac_out, cont_exp ? 8'h80 : v);
    if (!cont_exp) begin
      repeat (4) begin
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_dac", dac_out, v);
      end
    end
  endtask

  initial begin
    logic [7:0] v;
    int n;
    n_rst = 1'b0; start = 1'b0; cont = 1'b0; start3 = 1'b0; cont3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dac", dac_out, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst3_result", result3, 0);
    n_rst = 1'b1;

    conv(8'hA5, 1, 0, 8'hA5, -1, -1, -1);
    conv(8'h00, 1, 0, 8'h00, -1, -1, -1);
    conv(8'hFF, 1, 0, 8'hFF, -1, -1, -1);
    repeat (5) begin
      v = 8'($urandom);
      conv(v, 1, 0, v, -1, -1, -1);
    end

    v = 8'($urandom);
    conv(v, 1, 0, v, 5, 20, -1);

    cont = 1'b1;
    conv(8'h10, 1, 1, 8'hEF, -1, -1, -1);
    conv(8'hEF, 0, 0, 8'hEF, -1, -1, 10);

    vin = 8'h5A;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("arst_dac", dac_out, 0);
    chk("arst_result", result, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    repeat (3) @(negedge clk);
    chk("arst_hold", result, 0);
    n_rst = 1'b1;
    conv(8'h5A, 1, 0, 8'h5A, -1, -1, -1);

    for (int k = 0; k < 4; k++) begin
      v = (k == 0) ? 8'h3C : 8'($urandom);
      vin3 = v;
      @(posedge clk); #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!done3 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("lat3", n, 24);
      chk("result3", result3, v);
      chk("busy3_end", busy3, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
